// File: rtl/hit_writeback.sv
// hit_writeback: filters per-ray closest-hit records, buffers them in a small
// FIFO and writes them to result memory at address = ray ID.
module hit_writeback #(
  parameter int NUM_RAYS   = 1024,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ray_id,
  input  logic              in_hit,
  input  logic [31:0]       in_hitT,
  input  logic [31:0]       in_tri_index,
  output logic              mem_wr_en,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [63:0]       mem_wr_data,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic              dup_error,
  output logic              range_error,
  output logic              done,
  output logic [63:0]       frame_cycles
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } rec_t;

  rec_t                fifo [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         count;
  logic [NUM_RAYS-1:0] seen;
  logic [31:0]         written;
  logic                started;

  logic              full;
  logic              accept;
  logic              in_range;
  logic              fresh;
  logic              pop;
  logic [ADDR_W-1:0] id;
  logic [63:0]       push_data;

  assign full     = count == (PW+1)'(FIFO_DEPTH);
  assign in_ready = ~reset & ~full;
  assign accept   = in_valid & in_ready;
  assign in_range = in_ray_id < 32'(NUM_RAYS);
  assign id       = in_ray_id[ADDR_W-1:0];
  assign fresh    = accept & in_range & ~seen[id];
  assign pop      = mem_wr_en & mem_wr_ready;

  // misses are stored as +inf distance with an all-ones triangle index
  assign push_data = in_hit ? {in_tri_index, in_hitT}
                            : {32'hFFFF_FFFF, 32'h7F80_0000};

  assign mem_wr_en   = count != '0;
  assign mem_wr_addr = mem_wr_en ? fifo[rd_ptr].addr : '0;
  assign mem_wr_data = mem_wr_en ? fifo[rd_ptr].data : '0;

  always_ff @(posedge clock) begin
    if (fresh) fifo[wr_ptr] <= '{addr: id, data: push_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      seen         <= '0;
      written      <= '0;
      started      <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      dup_error    <= 1'b0;
      range_error  <= 1'b0;
      done         <= 1'b0;
      frame_cycles <= '0;
    end else begin
      if (fresh) begin
        seen[id] <= 1'b1;
        wr_ptr   <= wr_ptr + 1'b1;
        if (in_hit) hit_count  <= hit_count + 32'd1;
        else        miss_count <= miss_count + 32'd1;
      end
      if (accept & ~in_range) range_error <= 1'b1;
      if (accept & in_range & seen[id]) dup_error <= 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        written <= written + 32'd1;
      end
      unique case (1'b1)
        fresh & ~pop: count <= count + 1'b1;
        pop & ~fresh: count <= count - 1'b1;
        default:      count <= count;
      endcase
      if (pop && written == 32'(NUM_RAYS - 1)) done <= 1'b1;
      if (accept) started <= 1'b1;
      // counts through the edge where done rises, then freezes
      if (started && !done) frame_cycles <= frame_cycles + 64'd1;
    end
  end

endmodule
